// File: rtl/recovery_frame_sequencer.sv
// recovery_frame_sequencer: frames streamed samples, runs the loop block, drains its result and schedules recalibration
// Ports: clk/reset (sync, active-high); s_valid/s_ready/s_data input stream;
// m_valid/m_ready/m_data/m_last output stream; recal request pulse;
// lb_en/lb_reset/lb_in/lb_out/lb_k_found loop-block interface; busy, frame_cnt status.
// Define RECOVERY_AUTO_RECAL_EN to recalibrate automatically every RECAL_PERIOD launches.
module recovery_frame_sequencer #(
  parameter int OUT_RES      = 32,
  parameter int ROWS         = 8,
  parameter int CAL_CYCLES   = 200,
  parameter int RUN_CYCLES   = 64,
  parameter int RECAL_PERIOD = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic signed [OUT_RES-1:0]       s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic signed [OUT_RES-1:0]       m_data,
  output logic                            m_last,
  input  logic                            recal,
  output logic                            lb_en,
  output logic                            lb_reset,
  output logic [ROWS-1:0][OUT_RES-1:0]    lb_in,
  input  logic [ROWS-1:0][OUT_RES-1:0]    lb_out,
  input  logic                            lb_k_found,
  output logic                            busy,
  output logic [15:0]                     frame_cnt
);
  localparam int CW = $clog2(ROWS + 1);
  localparam int IW = $clog2(ROWS);
  localparam int WW = $clog2((CAL_CYCLES > RUN_CYCLES ? CAL_CYCLES : RUN_CYCLES) + 1);
  localparam logic [CW-1:0] FULL = CW'(ROWS);
  localparam logic [IW-1:0] LAST = IW'(ROWS - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ROWS-1:0][OUT_RES-1:0] in_buf_q, in_buf_d, lb_in_q, lb_in_d, out_buf_q, out_buf_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic out_full_q, out_full_d, recal_pend_q, recal_pend_d, recal_fire_q, recal_fire_d;
  logic launch, s_hs, m_hs, auto_hit;
  assign launch    = state_q == LAUNCH;
  assign s_ready   = in_cnt_q < FULL;
  assign s_hs      = s_valid && s_ready;
  assign m_valid   = state_q == DRAIN;
  assign m_hs      = m_valid && m_ready;
  assign m_data    = m_valid ? out_buf_q[out_idx_q] : '0;
  assign m_last    = m_valid && out_idx_q == LAST;
  assign lb_en     = launch;
  assign lb_reset  = reset || recal_fire_q;
  assign lb_in     = lb_in_q;
  assign busy      = state_q != IDLE;
  assign frame_cnt = frame_cnt_q;
`ifdef RECOVERY_AUTO_RECAL_EN
  logic [15:0] launch_cnt_q, launch_cnt_d;
  always_comb begin
    auto_hit     = launch && (launch_cnt_q + 16'd1 == 16'(RECAL_PERIOD));
    launch_cnt_d = (recal || auto_hit) ? '0 : launch ? launch_cnt_q + 16'd1 : launch_cnt_q;
  end
  always_ff @(posedge clk) launch_cnt_q <= reset ? '0 : launch_cnt_d;
`else
  assign auto_hit = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    in_buf_d     = in_buf_q;
    in_cnt_d     = in_cnt_q;
    lb_in_d      = lb_in_q;
    out_buf_d    = out_buf_q;
    out_idx_d    = out_idx_q;
    out_full_d   = out_full_q;
    wait_cnt_d   = wait_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    recal_fire_d = 1'b0;
    if (s_hs) begin
      in_buf_d[in_cnt_q[IW-1:0]] = s_data;
      in_cnt_d = in_cnt_q + CW'(1);
    end
    case (state_q)
      IDLE:
        if (recal_pend_q) recal_fire_d = 1'b1;
        else if (in_cnt_q == FULL && !out_full_q) begin
          // loaded on entry so lb_in is already valid while lb_en is high
          lb_in_d = in_buf_q;
          state_d = LAUNCH;
        end
      LAUNCH: begin
        in_cnt_d   = '0;
        wait_cnt_d = lb_k_found ? WW'(RUN_CYCLES - 1) : WW'(CAL_CYCLES - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WW'(1);
        if (wait_cnt_q == '0) state_d = CAPTURE;
      end
      CAPTURE: begin
        out_buf_d  = lb_out;
        out_idx_d  = '0;
        out_full_d = 1'b1;
        state_d    = DRAIN;
      end
      DRAIN:
        if (m_hs) begin
          out_idx_d = out_idx_q + IW'(1);
          if (out_idx_q == LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            out_full_d  = 1'b0;
            state_d     = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
    // a request arriving in the same cycle as service stays pending
    recal_pend_d = (recal_fire_d ? 1'b0 : recal_pend_q) || recal || auto_hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_buf_q     <= '0;
      in_cnt_q     <= '0;
      lb_in_q      <= '0;
      out_buf_q    <= '0;
      out_idx_q    <= '0;
      out_full_q   <= 1'b0;
      wait_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      recal_pend_q <= 1'b0;
      recal_fire_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_buf_q     <= in_buf_d;
      in_cnt_q     <= in_cnt_d;
      lb_in_q      <= lb_in_d;
      out_buf_q    <= out_buf_d;
      out_idx_q    <= out_idx_d;
      out_full_q   <= out_full_d;
      wait_cnt_q   <= wait_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      recal_pend_q <= recal_pend_d;
      recal_fire_q <= recal_fire_d;
    end
  end
endmodule

// File: tb/tb_recovery_frame_sequencer.sv
// tb_recovery_frame_sequencer: directed bench with a stub loop block returning in+1
module tb_recovery_frame_sequencer;
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, m_ready = 1'b1, recal = 1'b0;
  logic s_ready, m_valid, m_last, lb_en, lb_reset, busy, k_found = 1'b0;
  logic signed [31:0] s_data = '0, m_data;
  logic [3:0][31:0] lb_in, lb_out;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0, en_long = 0;
  logic en_prev = 1'b0, mv_prev = 1'b0;
  logic [31:0] dq[$];
  logic lq[$];
  int en_cyc[$], mv_cyc[$], exit_cyc[$], rst_cyc[$];
  recovery_frame_sequencer #(.OUT_RES(32), .ROWS(4), .CAL_CYCLES(20), .RUN_CYCLES(10), .RECAL_PERIOD(3)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .recal(recal),
    .lb_en(lb_en), .lb_reset(lb_reset), .lb_in(lb_in), .lb_out(lb_out), .lb_k_found(k_found),
    .busy(busy), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 4; i++) lb_out[i] = lb_in[i] + 32'd1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    k_found <= lb_reset ? 1'b0 : lb_en ? 1'b1 : k_found;
  end
  always @(negedge clk) begin
    if (lb_en) en_cyc.push_back(cyc);
    if (lb_en && en_prev) en_long <= en_long + 1;
    if (m_valid && !mv_prev) mv_cyc.push_back(cyc);
    if (m_valid && m_ready) begin
      dq.push_back(m_data);
      lq.push_back(m_last);
      if (m_last) exit_cyc.push_back(cyc);
    end
    if (lb_reset && !reset) rst_cyc.push_back(cyc);
    en_prev <= lb_en;
    mv_prev <= m_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input int v);
    int t = 0;
    while (!s_ready && t < 500) begin step; t++; end
    s_valid = 1'b1;
    s_data  = v;
    step;
    s_valid = 1'b0;
  endtask
  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask
  task automatic wait_fc(input logic [15:0] n);
    int t = 0;
    while (frame_cnt !== n && t < 300) begin step; t++; end
    chk("frame_cnt", frame_cnt, n);
  endtask
  task automatic wait_en(input int n);
    int t = 0;
    while (en_cyc.size() < n && t < 300) begin step; t++; end
    chk("launch seen", en_cyc.size(), n);
  endtask
  task automatic chk_frame(input string tag, input int fo, input int fe, input int e0, input int e1,
                           input int e2, input int e3, input int lat);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      chk({tag, " data"}, dq[fo*4+i], ex[i]);
      chk({tag, " last"}, {31'd0, lq[fo*4+i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    chk({tag, " latency"}, mv_cyc[fo] - en_cyc[fe], lat);
  endtask
  initial begin
    step; step;
    chk("rst lb_reset", lb_reset, 1);
    chk("rst m_valid", m_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst m_last", m_last, 0);
    chk("rst m_data", m_data, 0);
    chk("rst lb_en", lb_en, 0);
    reset = 1'b0;
    step;
    chk("idle lb_reset", lb_reset, 0);
    chk("idle s_ready", s_ready, 1);
    send4(1, 2, 3, 4);
    chk("full s_ready", s_ready, 0);
    send4(10, 20, 30, 40);
    chk("wait busy", busy, 1);
    wait_fc(1);
    wait_fc(2);
    chk_frame("f0", 0, 0, 2, 3, 4, 5, 22);
    chk_frame("f1", 1, 1, 11, 21, 31, 41, 12);
    chk("f1 relaunch gap", en_cyc[1] - exit_cyc[0], 2);
    send4(5, 6, 7, 8);
    begin
      int t = 0;
      while (!m_valid && t < 300) begin step; t++; end
    end
    chk("f2 m_valid", m_valid, 1);
    step;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stall m_data", m_data, 7);
      chk("stall m_valid", m_valid, 1);
    end
    m_ready = 1'b1;
    wait_fc(3);
    chk_frame("f2", 2, 2, 6, 7, 8, 9, 12);
    chk("f2 word count", dq.size(), 12);
    send4(100, 200, 300, 400);
    wait_en(4);
    step; step; step;
    recal = 1'b1; step; recal = 1'b0; step;
    recal = 1'b1; step; recal = 1'b0;
    send4(7, 8, 9, 10);
    wait_fc(4);
    wait_fc(5);
    chk_frame("f3", 3, 3, 101, 201, 301, 401, 12);
    chk_frame("f4", 4, 4, 8, 9, 10, 11, 22);
    chk("recal pulses", rst_cyc.size(), 1);
    chk("recal after drain", rst_cyc[0] - exit_cyc[3], 2);
    chk("launch after recal", en_cyc[4] - rst_cyc[0], 1);
    send4(1, 1, 1, 1);
    wait_en(6);
    step; step; step; step; step;
    reset = 1'b1;
    step;
    chk("mid rst lb_reset", lb_reset, 1);
    chk("mid rst m_valid", m_valid, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst frame_cnt", frame_cnt, 0);
    chk("mid rst s_ready", s_ready, 1);
    step;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) step;
    chk("discarded words", dq.size(), 20);
    chk("discarded busy", busy, 0);
    send4(3, 4, 5, 6);
    wait_fc(1);
    chk_frame("f6", 5, 6, 4, 5, 6, 7, 22);
    chk("total recal pulses", rst_cyc.size(), 1);
    chk("lb_en width", en_long, 0);
    chk("launch count", en_cyc.size(), 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
